// File: rtl/ttc_intr_pkg.sv
// Shared constants for the TTC interrupt controller: mode encodings, coalescing
// FSM states and default parameter values.
package ttc_intr_pkg;

  localparam int NUM_SRC_DEF  = 6;
  localparam int ID_W_DEF     = 3;
  localparam int COAL_TMO_DEF = 16;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  typedef logic [1:0] coal_state_t;
  localparam coal_state_t ST_IDLE  = 2'd0;
  localparam coal_state_t ST_ACCUM = 2'd1;
  localparam coal_state_t ST_FIRE  = 2'd2;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/ttc_intr_sync.sv
// Per-source two-flop synchroniser plus history flop; produces an edge or
// level event depending on the source's mode bit.
module ttc_intr_sync
  import ttc_intr_pkg::*;
(
  input  logic pclk,
  input  logic n_p_reset,
  input  logic src,
  input  logic mode,
  output logic evt
);

  logic s1_reg, s2_reg, s3_reg;

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      s1_reg <= 1'b0;
      s2_reg <= 1'b0;
      s3_reg <= 1'b0;
    end else begin
      s1_reg <= src;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  // The history flop keeps running across mode changes, so a level that is
  // already high when switching to edge mode does not look like a new edge.
  assign evt = (mode == MODE_EDGE) ? (s2_reg & ~s3_reg) : s2_reg;

endmodule

// File: rtl/ttc_intr_ctrl.sv
// Interrupt controller: synchronised sources, sticky W1C status, enable/mode
// registers. Define TTC_INTR_COALESCE_EN to add count/timeout coalescing.
module ttc_intr_ctrl
  import ttc_intr_pkg::*;
#(
  parameter int NUM_SRC  = NUM_SRC_DEF,
  parameter int ID_W     = ID_W_DEF,
  parameter int COAL_TMO = COAL_TMO_DEF
) (
  input  logic               pclk,
  input  logic               n_p_reset,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] pwdata,
  input  logic               en_wr,
  input  logic               mode_wr,
  input  logic               clr_wr,
`ifdef TTC_INTR_COALESCE_EN
  input  logic [3:0]         coal_thresh,
`endif
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_status,
  output logic [NUM_SRC-1:0] irq_en_out,
  output logic [NUM_SRC-1:0] irq_mode_out
);

  localparam int ID_W_REQ = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  if (NUM_SRC < 1 || NUM_SRC > 32 || ID_W != ID_W_REQ || COAL_TMO < 1 || COAL_TMO > 255)
  begin : g_param_check
    $error("ttc_intr_ctrl: illegal NUM_SRC/ID_W/COAL_TMO combination");
  end

  logic [NUM_SRC-1:0] en_reg, mode_reg, status_reg, status_next, evt;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    ttc_intr_sync u_sync (
      .pclk      (pclk),
      .n_p_reset (n_p_reset),
      .src       (src_in[gi]),
      .mode      (mode_reg[gi]),
      .evt       (evt[gi])
    );
    // A set in the same cycle as its clear wins, so no event is lost.
    assign status_next[gi] = (status_reg[gi] & ~(clr_wr & pwdata[gi])) | (evt[gi] & en_reg[gi]);
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      en_reg     <= '0;
      mode_reg   <= '0;
      status_reg <= '0;
    end else begin
      status_reg <= status_next;
      if (en_wr)   en_reg   <= pwdata;
      if (mode_wr) mode_reg <= pwdata;
    end
  end

  always_comb begin
    irq_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (status_reg[i]) irq_id = ID_W'(i);
    end
  end

  assign irq_status   = status_reg;
  assign irq_en_out   = en_reg;
  assign irq_mode_out = mode_reg;

`ifdef TTC_INTR_COALESCE_EN
  coal_state_t state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [7:0]  tmr_reg, tmr_next;
  logic [5:0]  new_cnt;
  logic [5:0]  cnt_sum;

  assign new_cnt = popcount32(32'(status_next & ~status_reg));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    tmr_next   = tmr_reg;
    cnt_sum    = 6'(cnt_reg) + new_cnt;
    case (state_reg)
      ST_IDLE: begin
        if (new_cnt != 6'd0) begin
          state_next = ST_ACCUM;
          cnt_next   = (new_cnt > 6'd15) ? 4'hF : new_cnt[3:0];
          tmr_next   = 8'd0;
        end
      end
      ST_ACCUM: begin
        cnt_next = (cnt_sum > 6'd15) ? 4'hF : cnt_sum[3:0];
        tmr_next = tmr_reg + 8'd1;
        if (cnt_next >= coal_thresh || tmr_next == 8'(COAL_TMO)) state_next = ST_FIRE;
      end
      ST_FIRE: begin
        if (status_next == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      tmr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      tmr_reg   <= tmr_next;
    end
  end

  assign irq = (state_reg == ST_FIRE);
`else
  assign irq = |status_reg;
`endif

endmodule

// File: tb/tb_ttc_intr_ctrl.sv
// Self-checking bench for ttc_intr_ctrl (default build): directed scenarios
// followed by random traffic, checked against a delay-line reference model.
module tb_ttc_intr_ctrl;

  localparam int N = 6;

  logic         pclk = 1'b0;
  logic         n_p_reset;
  logic [N-1:0] src_in, pwdata;
  logic         en_wr, mode_wr, clr_wr;
  logic         irq;
  logic [2:0]   irq_id;
  logic [N-1:0] irq_status, irq_en_out, irq_mode_out;
`ifdef TTC_INTR_COALESCE_EN
  logic [3:0]   coal_thresh = 4'd1;
`endif

  ttc_intr_ctrl #(.NUM_SRC(N), .ID_W(3), .COAL_TMO(16)) dut (
    .pclk         (pclk),
    .n_p_reset    (n_p_reset),
    .src_in       (src_in),
    .pwdata       (pwdata),
    .en_wr        (en_wr),
    .mode_wr      (mode_wr),
    .clr_wr       (clr_wr),
`ifdef TTC_INTR_COALESCE_EN
    .coal_thresh  (coal_thresh),
`endif
    .irq          (irq),
    .irq_id       (irq_id),
    .irq_status   (irq_status),
    .irq_en_out   (irq_en_out),
    .irq_mode_out (irq_mode_out)
  );

  always #5 pclk = ~pclk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  // Reference model: a source value becomes visible to the status logic two
  // edges after it is sampled; edge detection compares it with the sample
  // taken one edge before that.
  logic [N-1:0] samp_q[$];
  logic [N-1:0] m_status, m_en, m_mode;

  task automatic model_reset();
    samp_q = {};
    for (int i = 0; i < 3; i++) samp_q.push_back('0);
    m_status = '0;
    m_en     = '0;
    m_mode   = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] seen, prev, ev;
    seen = samp_q[1];
    prev = samp_q[2];
    ev = (m_mode & seen & ~prev) | (~m_mode & seen);
    m_status = (m_status & ~(clr_wr ? pwdata : '0)) | (ev & m_en);
    if (en_wr)   m_en   = pwdata;
    if (mode_wr) m_mode = pwdata;
    samp_q.push_front(src_in);
    void'(samp_q.pop_back());
  endtask

  function automatic logic [31:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("status", 32'(irq_status), 32'(m_status));
    chk("irq_id", 32'(irq_id), lowest(m_status));
    chk("irq", 32'(irq), 32'(|m_status));
    chk("en", 32'(irq_en_out), 32'(m_en));
    chk("mode", 32'(irq_mode_out), 32'(m_mode));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_id"}, 32'(irq_id), 0);
    chk({tag, "_status"}, 32'(irq_status), 0);
    chk({tag, "_en"}, 32'(irq_en_out), 0);
    chk({tag, "_mode"}, 32'(irq_mode_out), 0);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] d,
                     input logic ew, input logic mw, input logic cw);
    src_in  = s;
    pwdata  = d;
    en_wr   = ew;
    mode_wr = mw;
    clr_wr  = cw;
    @(posedge pclk);
    model_step();
    #1;
    chk_model();
  endtask

  // Called at posedge+1; asserts reset between edges and checks it acts at once.
  task automatic mid_reset(input string tag);
    #2 n_p_reset = 1'b0;
    #1 chk_all_zero(tag);
    model_reset();
    @(posedge pclk);
    #3 n_p_reset = 1'b1;
  endtask

  initial begin
    n_p_reset = 1'b0;
    src_in = '0; pwdata = '0; en_wr = 0; mode_wr = 0; clr_wr = 0;
    model_reset();
    #3 chk_all_zero("reset");
    #9 n_p_reset = 1'b1;
    cyc(6'h00, 6'h00, 0, 0, 0);

    // Edge mode: one-cycle pulse on source 2
    $display("step: edge pulse on src 2");
    cyc(6'h00, 6'h3F, 1, 1, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h04, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    chk("edge_k1_status", 32'(irq_status), 32'h00);
    cyc(6'h00, 6'h00, 0, 0, 0);
    chk("edge_k2_status", 32'(irq_status), 32'h04);
    chk("edge_k2_irq", 32'(irq), 1);
    chk("edge_k2_id", 32'(irq_id), 2);
    cyc(6'h00, 6'h3F, 0, 0, 1);
    chk("edge_clear", 32'(irq_status), 32'h00);

    // Set/clear collision on bit 3
    $display("step: set/clear collision on bit 3");
    cyc(6'h08, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h08, 0, 0, 1);
    chk("collide_bit3", 32'(irq_status[3]), 1);
    cyc(6'h00, 6'h3F, 0, 0, 1);

    // Level mode: held source re-asserts through a clear
    $display("step: level re-assert on src 0");
    cyc(6'h00, 6'h00, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(6'h01, 6'h00, 0, 0, 0);
    cyc(6'h01, 6'h01, 0, 0, 1);
    cyc(6'h01, 6'h00, 0, 0, 0);
    chk("level_reset_bit0", 32'(irq_status), 32'h01);
    chk("level_irq", 32'(irq), 1);
    for (int i = 0; i < 3; i++) cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h01, 0, 0, 1);
    chk("level_cleared", 32'(irq_status), 32'h00);

    // Switching a high level source to edge mode yields no new event
    $display("step: level->edge switch with src 1 high");
    for (int i = 0; i < 4; i++) cyc(6'h02, 6'h00, 0, 0, 0);
    cyc(6'h02, 6'h3F, 0, 1, 0);
    cyc(6'h02, 6'h3F, 0, 0, 1);
    cyc(6'h02, 6'h00, 0, 0, 0);
    cyc(6'h02, 6'h00, 0, 0, 0);
    chk("mode_switch_no_evt", 32'(irq_status), 32'h00);
    for (int i = 0; i < 3; i++) cyc(6'h00, 6'h00, 0, 0, 0);

    // Enable mask and priority
    $display("step: enable 0x05, sources 0..2 rise together");
    cyc(6'h00, 6'h05, 1, 0, 0);
    cyc(6'h07, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    chk("prio_status", 32'(irq_status), 32'h05);
    chk("prio_id0", 32'(irq_id), 0);
    cyc(6'h00, 6'h01, 0, 0, 1);
    chk("prio_id2", 32'(irq_id), 2);
    cyc(6'h00, 6'h00, 1, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    chk("disable_keeps", 32'(irq_status), 32'h04);
    cyc(6'h00, 6'h3F, 0, 0, 1);

    // Reset in the middle of a pending pulse
    $display("step: reset mid-pulse");
    cyc(6'h00, 6'h3F, 1, 0, 0);
    cyc(6'h01, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h00, 6'h00, 0, 0, 0);
    cyc(6'h10, 6'h00, 0, 0, 0);
    mid_reset("midrst");
    for (int i = 0; i < 4; i++) cyc(6'h00, 6'h00, 0, 0, 0);
    chk("post_reset_status", 32'(irq_status), 32'h00);

    // Random traffic
    $display("step: random traffic");
    for (int t = 0; t < 500; t++) begin
      logic [N-1:0] s, d;
      s = (t % 3 == 0) ? N'($urandom) : src_in;
      d = N'($urandom);
      cyc(s, d, $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0);
      if ($urandom_range(149) == 0) mid_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
